// File: rtl/ets_pkg.sv
// Shared widths, response codes and FSM encoding for the seat-inventory arbiter.
package ets_pkg;

   localparam int ROUTE_W = 4;
   localparam int CNT_W   = 4;
   localparam int SEAT_W  = 6;

   localparam logic [CNT_W-1:0] MAX_COUNT = 4'd9;

   localparam logic [1:0] RSP_OK     = 2'd0;
   localparam logic [1:0] RSP_INSUFF = 2'd1;
   localparam logic [1:0] RSP_BADREQ = 2'd2;
   localparam logic [1:0] RSP_OVFL   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

endpackage

// File: rtl/ets_rr_arbiter.sv
// Combinational round-robin picker: first requester after last_grant_i wins.
module ets_rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] last_grant_i,
   output logic [IDX_W-1:0] grant_o,
   output logic             any_req_o
);

   int  idx;
   logic found;

   // Walk the ring starting just past the previous winner.
   always_comb begin
      grant_o = '0;
      found   = 1'b0;
      idx     = 0;
      for (int i = 1; i <= N; i++) begin
         idx = (int'(last_grant_i) + i) % N;
         if (!found && req_i[idx]) begin
            grant_o = IDX_W'(idx);
            found   = 1'b1;
         end
      end
      any_req_o = found;
   end

endmodule

// File: rtl/ets_seat_arbiter.sv
// Multi-kiosk seat inventory: serialises reserve/release requests against one per-route table.
module ets_seat_arbiter
   import ets_pkg::*;
#(
   parameter int N_KIOSK    = 4,
   parameter int N_ROUTE    = 9,
   parameter int SEATS_INIT = 50
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [N_KIOSK-1:0]         req_valid,
   input  logic [N_KIOSK-1:0]         req_op,
   input  logic [ROUTE_W*N_KIOSK-1:0] req_route,
   input  logic [CNT_W*N_KIOSK-1:0]   req_count,
   output logic [N_KIOSK-1:0]         req_ready,
   input  logic                       restock,
   output logic                       rsp_valid,
   output logic [2:0]                 rsp_kiosk,
   output logic [1:0]                 rsp_code,
   output logic [SEAT_W-1:0]          rsp_left,
   input  logic [ROUTE_W-1:0]         qry_route,
   output logic [SEAT_W-1:0]          qry_left
);

   localparam int IDX_W = (N_KIOSK > 1) ? $clog2(N_KIOSK) : 1;
   localparam logic [SEAT_W-1:0] SEATS_FULL = SEAT_W'(SEATS_INIT);

   state_t               state_q;
   logic [IDX_W-1:0]     lastGrant_q, kiosk_q;
   logic                 op_q;
   logic [ROUTE_W-1:0]   route_q;
   logic [CNT_W-1:0]     count_q;
   logic [SEAT_W-1:0]    seats_q [1:N_ROUTE];
   logic [N_KIOSK-1:0]   reqReady_q;
   logic                 rspValid_q;
   logic [2:0]           rspKiosk_q;
   logic [1:0]           rspCode_q;
   logic [SEAT_W-1:0]    rspLeft_q, qryLeft_q;

   logic [IDX_W-1:0]     grantIdx;
   logic                 anyReq;
   logic                 routeOk, countOk, write_d;
   logic [SEAT_W-1:0]    seatsCur, left_d, qrySeat_d;
   logic [SEAT_W:0]      relSum;
   logic [1:0]           code_d;

   ets_rr_arbiter #(.N(N_KIOSK), .IDX_W(IDX_W)) u_arb (
      .req_i        (req_valid),
      .last_grant_i (lastGrant_q),
      .grant_o      (grantIdx),
      .any_req_o    (anyReq)
   );

   // Verdict for the latched request; release uses a one-bit-wider sum so it cannot wrap.
   always_comb begin
      routeOk  = (route_q != '0) && (int'(route_q) <= N_ROUTE);
      countOk  = (count_q != '0) && (count_q <= MAX_COUNT);
      seatsCur = '0;
      if (routeOk) seatsCur = seats_q[route_q];
      relSum   = {1'b0, seatsCur} + (SEAT_W+1)'(count_q);
      code_d   = RSP_OK;
      left_d   = seatsCur;
      write_d  = 1'b0;
      if (!routeOk || !countOk) begin
         code_d = RSP_BADREQ;
      end else if (!op_q) begin
         if (SEAT_W'(count_q) > seatsCur) begin
            code_d = RSP_INSUFF;
         end else begin
            left_d  = seatsCur - SEAT_W'(count_q);
            write_d = 1'b1;
         end
      end else if (relSum > (SEAT_W+1)'(SEATS_INIT)) begin
         code_d = RSP_OVFL;
      end else begin
         left_d  = relSum[SEAT_W-1:0];
         write_d = 1'b1;
      end
      qrySeat_d = '0;
      if ((qry_route != '0) && (int'(qry_route) <= N_ROUTE)) qrySeat_d = seats_q[qry_route];
   end

   // Sequencer: grant in IDLE, update table in CHECK, strobe in RESP; restock overrides table writes.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         lastGrant_q <= IDX_W'(N_KIOSK - 1);
         kiosk_q     <= '0;
         op_q        <= 1'b0;
         route_q     <= '0;
         count_q     <= '0;
         reqReady_q  <= '0;
         rspValid_q  <= 1'b0;
         rspKiosk_q  <= '0;
         rspCode_q   <= '0;
         rspLeft_q   <= '0;
         qryLeft_q   <= '0;
         for (int r = 1; r <= N_ROUTE; r++) seats_q[r] <= SEATS_FULL;
      end else begin
         reqReady_q <= '0;
         rspValid_q <= 1'b0;
         qryLeft_q  <= qrySeat_d;
         case (state_q)
            ST_IDLE: begin
               if (anyReq) begin
                  kiosk_q               <= grantIdx;
                  lastGrant_q           <= grantIdx;
                  op_q                  <= req_op[grantIdx];
                  route_q               <= req_route[int'(grantIdx)*ROUTE_W +: ROUTE_W];
                  count_q               <= req_count[int'(grantIdx)*CNT_W +: CNT_W];
                  reqReady_q[grantIdx]  <= 1'b1;
                  state_q               <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (write_d) seats_q[route_q] <= left_d;
               rspValid_q <= 1'b1;
               rspKiosk_q <= 3'(kiosk_q);
               rspCode_q  <= code_d;
               rspLeft_q  <= restock ? SEATS_FULL : left_d;
               state_q    <= ST_RESP;
            end
            ST_RESP: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
         if (restock) begin
            for (int r = 1; r <= N_ROUTE; r++) seats_q[r] <= SEATS_FULL;
         end
      end
   end

   assign req_ready = reqReady_q;
   assign rsp_valid = rspValid_q;
   assign rsp_kiosk = rspKiosk_q;
   assign rsp_code  = rspCode_q;
   assign rsp_left  = rspLeft_q;
   assign qry_left  = qryLeft_q;

endmodule

// File: tb/tb_ets_seat_arbiter.sv
// Directed self-checking bench for ets_seat_arbiter with hand-computed expectations.
module tb_ets_seat_arbiter;

   localparam logic [1:0] C_OK     = 2'd0;
   localparam logic [1:0] C_INSUFF = 2'd1;
   localparam logic [1:0] C_BADREQ = 2'd2;
   localparam logic [1:0] C_OVFL   = 2'd3;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [3:0]  req_op = '0;
   logic [15:0] req_route = '0;
   logic [15:0] req_count = '0;
   logic [3:0]  req_ready;
   logic        restock = 1'b0;
   logic        rsp_valid;
   logic [2:0]  rsp_kiosk;
   logic [1:0]  rsp_code;
   logic [5:0]  rsp_left;
   logic [3:0]  qry_route = '0;
   logic [5:0]  qry_left;

   int vectors = 0;
   int miscompares = 0;

   ets_seat_arbiter #(.N_KIOSK(4), .N_ROUTE(9), .SEATS_INIT(50)) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_op    (req_op),
      .req_route (req_route),
      .req_count (req_count),
      .req_ready (req_ready),
      .restock   (restock),
      .rsp_valid (rsp_valid),
      .rsp_kiosk (rsp_kiosk),
      .rsp_code  (rsp_code),
      .rsp_left  (rsp_left),
      .qry_route (qry_route),
      .qry_left  (qry_left)
   );

   always #5 clock = ~clock;

   task automatic doReset();
      reset = 1'b1;
      req_valid = '0;
      restock = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   // One complete transaction for kiosk k; returns what the DUT reported and when.
   task automatic runTxn(input int k, input logic op, input int route, input int cnt,
                         output logic [1:0] code, output logic [5:0] left, output logic [2:0] kid,
                         output int readyCyc, output int rspCyc);
      code = 'x; left = 'x; kid = 'x; readyCyc = 0; rspCyc = 0;
      req_op[k] = op;
      req_route[4*k +: 4] = 4'(route);
      req_count[4*k +: 4] = 4'(cnt);
      req_valid[k] = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clock); #1;
         if (req_ready[k] && readyCyc == 0) begin
            readyCyc = c;
            req_valid[k] = 1'b0;
         end
         if (rsp_valid) begin
            rspCyc = c; code = rsp_code; left = rsp_left; kid = rsp_kiosk;
            break;
         end
      end
      req_valid[k] = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic readQry(input int r, output logic [5:0] v);
      qry_route = 4'(r);
      @(posedge clock); #1;
      v = qry_left;
   endtask

   task automatic test_reset();
      logic [5:0] v;
      reset = 1'b1;
      qry_route = 4'd3;
      repeat (3) @(posedge clock);
      #1;
      vectors++; if (req_ready !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_req_ready: got %0h want 0", req_ready); end
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rsp_valid: got %0b want 0", rsp_valid); end
      vectors++; if ({rsp_kiosk, rsp_code, rsp_left} !== 11'd0) begin miscompares++; $display("[TB] FAIL reset_rsp_fields: got k%0d c%0d l%0d want 0", rsp_kiosk, rsp_code, rsp_left); end
      vectors++; if (qry_left !== 6'd0) begin miscompares++; $display("[TB] FAIL reset_qry_left: got %0d want 0", qry_left); end
      reset = 1'b0;
      @(posedge clock); #1;
      vectors++; if (qry_left !== 6'd50) begin miscompares++; $display("[TB] FAIL reset_seats_r3: got %0d want 50", qry_left); end
      readQry(0, v);
      vectors++; if (v !== 6'd0) begin miscompares++; $display("[TB] FAIL qry_route0: got %0d want 0", v); end
      readQry(10, v);
      vectors++; if (v !== 6'd0) begin miscompares++; $display("[TB] FAIL qry_route10: got %0d want 0", v); end
   endtask

   task automatic test_basic();
      logic [1:0] code; logic [5:0] left, v; logic [2:0] kid; int rc, sc;
      runTxn(0, 1'b0, 3, 5, code, left, kid, rc, sc);
      vectors++; if (rc !== 1) begin miscompares++; $display("[TB] FAIL basic_ready_latency: got %0d want 1", rc); end
      vectors++; if (sc !== 2) begin miscompares++; $display("[TB] FAIL basic_rsp_latency: got %0d want 2", sc); end
      vectors++; if (code !== C_OK) begin miscompares++; $display("[TB] FAIL basic_code: got %0d want %0d", code, C_OK); end
      vectors++; if (left !== 6'd45) begin miscompares++; $display("[TB] FAIL basic_left: got %0d want 45", left); end
      vectors++; if (kid !== 3'd0) begin miscompares++; $display("[TB] FAIL basic_kiosk: got %0d want 0", kid); end
      readQry(3, v);
      vectors++; if (v !== 6'd45) begin miscompares++; $display("[TB] FAIL basic_qry: got %0d want 45", v); end
   endtask

   task automatic test_round_robin();
      int grants [5];
      int cycles [5];
      int n = 0;
      doReset();
      for (int k = 0; k < 4; k++) begin
         req_op[k] = 1'b0; req_route[4*k +: 4] = 4'd1; req_count[4*k +: 4] = 4'd1;
      end
      req_valid = 4'hF;
      for (int c = 1; c <= 40 && n < 5; c++) begin
         @(posedge clock); #1;
         for (int j = 0; j < 4; j++) begin
            if (req_ready[j] && n < 5) begin
               grants[n] = j; cycles[n] = c; n++;
            end
         end
      end
      req_valid = '0;
      repeat (4) @(posedge clock);
      #1;
      vectors++; if (n !== 5) begin miscompares++; $display("[TB] FAIL rr_grant_count: got %0d want 5", n); end
      for (int i = 0; i < n; i++) begin
         vectors++; if (grants[i] !== i % 4) begin miscompares++; $display("[TB] FAIL rr_order[%0d]: got %0d want %0d", i, grants[i], i % 4); end
         if (i > 0) begin
            vectors++; if (cycles[i] - cycles[i-1] !== 3) begin miscompares++; $display("[TB] FAIL rr_spacing[%0d]: got %0d want 3", i, cycles[i] - cycles[i-1]); end
         end
      end
   endtask

   task automatic test_insufficient();
      logic [1:0] code; logic [5:0] left, v; logic [2:0] kid; int rc, sc;
      for (int i = 1; i <= 5; i++) begin
         runTxn(1, 1'b0, 7, 9, code, left, kid, rc, sc);
         vectors++; if (code !== C_OK || left !== 6'(50 - 9*i)) begin miscompares++; $display("[TB] FAIL r7_reserve9[%0d]: got c%0d l%0d want c0 l%0d", i, code, left, 50 - 9*i); end
      end
      runTxn(1, 1'b0, 7, 6, code, left, kid, rc, sc);
      vectors++; if (code !== C_INSUFF || left !== 6'd5) begin miscompares++; $display("[TB] FAIL r7_insuff: got c%0d l%0d want c1 l5", code, left); end
      readQry(7, v);
      vectors++; if (v !== 6'd5) begin miscompares++; $display("[TB] FAIL r7_unchanged: got %0d want 5", v); end
      runTxn(2, 1'b0, 7, 5, code, left, kid, rc, sc);
      vectors++; if (code !== C_OK || left !== 6'd0 || kid !== 3'd2) begin miscompares++; $display("[TB] FAIL r7_drain: got c%0d l%0d k%0d want c0 l0 k2", code, left, kid); end
   endtask

   task automatic test_bad_req();
      int routes [4] = '{0, 10, 3, 3};
      int counts [4] = '{1, 1, 0, 10};
      logic [1:0] code; logic [5:0] left, v; logic [2:0] kid; int rc, sc;
      for (int i = 0; i < 4; i++) begin
         runTxn(0, 1'b0, routes[i], counts[i], code, left, kid, rc, sc);
         vectors++; if (code !== C_BADREQ) begin miscompares++; $display("[TB] FAIL badreq[%0d] r%0d n%0d: got %0d want 2", i, routes[i], counts[i], code); end
      end
      readQry(3, v);
      vectors++; if (v !== 6'd50) begin miscompares++; $display("[TB] FAIL badreq_r3_unchanged: got %0d want 50", v); end
   endtask

   task automatic test_overflow();
      logic [1:0] code; logic [5:0] left; logic [2:0] kid; int rc, sc;
      runTxn(3, 1'b1, 2, 1, code, left, kid, rc, sc);
      vectors++; if (code !== C_OVFL || left !== 6'd50 || kid !== 3'd3) begin miscompares++; $display("[TB] FAIL r2_ovfl: got c%0d l%0d k%0d want c3 l50 k3", code, left, kid); end
      runTxn(3, 1'b0, 2, 4, code, left, kid, rc, sc);
      vectors++; if (code !== C_OK || left !== 6'd46) begin miscompares++; $display("[TB] FAIL r2_reserve4: got c%0d l%0d want c0 l46", code, left); end
      runTxn(3, 1'b1, 2, 4, code, left, kid, rc, sc);
      vectors++; if (code !== C_OK || left !== 6'd50) begin miscompares++; $display("[TB] FAIL r2_release4: got c%0d l%0d want c0 l50", code, left); end
      runTxn(0, 1'b1, 7, 9, code, left, kid, rc, sc);
      vectors++; if (code !== C_OK || left !== 6'd9) begin miscompares++; $display("[TB] FAIL r7_release9: got c%0d l%0d want c0 l9", code, left); end
   endtask

   task automatic test_restock_check();
      logic [5:0] v;
      req_op[2] = 1'b0; req_route[8 +: 4] = 4'd5; req_count[8 +: 4] = 4'd3;
      req_valid[2] = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clock); #1;
         if (req_ready[2]) break;
      end
      req_valid[2] = 1'b0;
      restock = 1'b1;
      @(posedge clock); #1;
      restock = 1'b0;
      vectors++; if (rsp_valid !== 1'b1 || rsp_code !== C_OK || rsp_left !== 6'd50 || rsp_kiosk !== 3'd2) begin
         miscompares++; $display("[TB] FAIL restock_in_check: got v%0b c%0d l%0d k%0d want v1 c0 l50 k2", rsp_valid, rsp_code, rsp_left, rsp_kiosk);
      end
      @(posedge clock); #1;
      readQry(5, v);
      vectors++; if (v !== 6'd50) begin miscompares++; $display("[TB] FAIL restock_r5: got %0d want 50", v); end
      readQry(7, v);
      vectors++; if (v !== 6'd50) begin miscompares++; $display("[TB] FAIL restock_r7: got %0d want 50", v); end
   endtask

   task automatic test_reset_in_check();
      logic [5:0] v;
      logic sawRsp = 1'b0;
      logic [1:0] code; logic [5:0] left; logic [2:0] kid; int rc, sc;
      runTxn(1, 1'b0, 4, 7, code, left, kid, rc, sc);
      vectors++; if (code !== C_OK || left !== 6'd43) begin miscompares++; $display("[TB] FAIL r4_prefill: got c%0d l%0d want c0 l43", code, left); end
      req_op[1] = 1'b0; req_route[4 +: 4] = 4'd4; req_count[4 +: 4] = 4'd3;
      req_valid[1] = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clock); #1;
         if (req_ready[1]) break;
      end
      req_valid[1] = 1'b0;
      reset = 1'b1;
      @(posedge clock); #1;
      if (rsp_valid) sawRsp = 1'b1;
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clock); #1;
         if (rsp_valid) sawRsp = 1'b1;
      end
      vectors++; if (sawRsp !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_in_check_rsp: got 1 want 0"); end
      for (int r = 1; r <= 9; r++) begin
         readQry(r, v);
         vectors++; if (v !== 6'd50) begin miscompares++; $display("[TB] FAIL reload_r%0d: got %0d want 50", r, v); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round_robin();
      test_insufficient();
      test_bad_req();
      test_overflow();
      test_restock_check();
      test_reset_in_check();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ets_seat_arbiter.md
# ets_seat_arbiter

Shared seat-inventory controller for multi-kiosk ticket selling. N_KIOSK kiosk front-ends issue reserve or release requests for a route and a seat count. A round-robin arbiter serialises these requests against one per-route seat table, then returns an accept/reject code and the remaining seat count. The block owns the inventory; kiosks hold no seat state of their own.

## Interface
- N_KIOSK, 4, number of requesting kiosks (2..8)
- N_ROUTE, 9, number of routes; valid route ids 1..N_ROUTE
- SEATS_INIT, 50, per-route capacity loaded at reset/restock (≤63)
- clock  in  1  clock; all logic on posedge
- reset  in  1  reset, synchronous, active-high
- req_valid  in  N_KIOSK  per-kiosk request pending
- req_op  in  N_KIOSK  per-kiosk op: 0 reserve, 1 release (refund)
- req_route  in  4*N_KIOSK  per-kiosk route id, kiosk k at [4k+3:4k]
- req_count  in  4*N_KIOSK  per-kiosk seat count 1..9
- req_ready  out  N_KIOSK  one-cycle grant pulse to served kiosk
- restock  in  1  reload every route to SEATS_INIT
- rsp_valid  out  1  one-cycle response strobe
- rsp_kiosk  out  3  kiosk index the response belongs to
- rsp_code  out  2  0 OK, 1 INSUFFICIENT, 2 BAD_REQ, 3 OVERFLOW
- rsp_left  out  6  route seats after the operation (unchanged if not OK)
- qry_route  in  4  route to monitor
- qry_left  out  6  registered seats of qry_route, 0 for invalid id

## Operation
- FSM: IDLE -> CHECK -> RESP -> IDLE. One transaction every 3 cycles.
- IDLE: if any req_valid, the arbiter picks kiosk k, starting its search at last_grant+1 mod N_KIOSK. The block latches k, op, route and count, updates last_grant to k, and moves to CHECK.
- CHECK: evaluates the latched request against seats[route] and updates the table:
  - route 0 or > N_ROUTE, or count 0 or > 9 -> BAD_REQ.
  - reserve, count > seats -> INSUFFICIENT; else seats -= count, OK.
  - release, seats+count > SEATS_INIT -> OVERFLOW; else seats += count, OK.
- RESP: rsp_valid=1 with rsp_kiosk, rsp_code and rsp_left; the FSM then returns to IDLE.
- Arithmetic: 7-bit intermediate sum for release; no wrap. The stored value always stays in 0..SEATS_INIT.
- Requester rule: hold req_valid, op, route and count stable until req_ready. Deassert req_valid, or present a new request, no later than the cycle after req_ready.
- restock: at any state, sets all seats to SEATS_INIT at the edge. If restock coincides with the CHECK update, restock wins the table write. The response still reports the code computed from the pre-restock value, and rsp_left=SEATS_INIT.
- restock does not abort an in-flight transaction.

## Timing
- Edge E0 (IDLE, req_valid[k]=1): after E0, req_ready[k]=1 for exactly one cycle and state=CHECK.
- Edge E1: table updated; after E1, rsp_valid=1 for one cycle. Request-sampled to response is 2 cycles.
- Edge E2: state=IDLE. Edge E3 is the earliest sampling of the next request.
- qry_left: 1-cycle latency. It reflects the table value after the previous edge's write.
- Reset values:
  - state IDLE; last_grant=N_KIOSK-1, so kiosk 0 is served first.
  - req_ready=0, rsp_valid=0, rsp_kiosk=0, rsp_code=0, rsp_left=0, qry_left=0.
  - all seats=SEATS_INIT.
- Reset mid-transaction: the transaction is dropped, no response is issued, and the table is reloaded.
- Reset has priority over restock and requests.

## Structure
- ets_pkg holds:
  - ROUTE_W=4, CNT_W=4, SEAT_W=6.
  - rsp_code constants RSP_OK, RSP_INSUFF, RSP_BADREQ, RSP_OVFL.
  - FSM state encoding.
- Sub-module ets_rr_arbiter (parameter N): inputs req vector and last_grant; outputs grant index and any_req. Purely combinational picker; the pointer register stays in the parent.
- Seat table: N_ROUTE x SEAT_W register array, indexed 1..N_ROUTE.

## Test plan
- Reset, then kiosk0 reserves route 3, count 5 -> req_ready[0] one cycle later; rsp after 2 cycles with code OK, rsp_left=45; qry_route=3 gives qry_left=45.
- All 4 kiosks hold valid continuously -> grants in order 0,1,2,3,0, each 3 cycles apart; no kiosk granted twice in a row.
- Route 7: reserve 9 repeatedly until 5 seats are left, then reserve 6 -> INSUFFICIENT, rsp_left=5, table unchanged; then reserve 5 -> OK, left=0.
- Route 0, route 10, or count 0 -> BAD_REQ, no table change.
- On fresh route 2, release 1 -> OVERFLOW, left=50. Reserve 4 then release 4 -> OK, left=50.
- restock coincident with a CHECK reserve -> code OK, rsp_left=50. Reset asserted in CHECK -> no rsp_valid, all routes read 50.
